// File: rtl/fma16_vec_runner_if.sv
// Vector-memory read port and fma16 operand/result bundle for fma16_vec_runner.
// master = runner side, slave = memory + fma16 side.
interface fma16_vec_runner_if #(
    parameter int ADDR_W = 20
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [75:0]       mem_data;
    logic [15:0]       x, y, z;
    logic              mul, add, negp, negz;
    logic [1:0]        roundmode;
    logic [15:0]       result;
    logic [3:0]        flags;

    modport master (
        output mem_en, mem_addr, x, y, z, mul, add, negp, negz, roundmode,
        input  mem_data, result, flags
    );
    modport slave (
        input  mem_en, mem_addr, x, y, z, mul, add, negp, negz, roundmode,
        output mem_data, result, flags
    );
endinterface

// File: rtl/fma16_vec_runner.sv
// Test-vector sequencer/checker for fma16: fetch, unpack, drive, compare, log first failure.
// Define FMA16_RUNNER_FLAGS_EN to also compare flags and latch fail_flags/fail_flagsexp.
module fma16_vec_runner #(
    parameter int ADDR_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   nvecs,
    fma16_vec_runner_if.master  mif,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   vectornum,
    output logic [31:0]         errors,
    output logic                fail_valid,
    output logic [ADDR_W-1:0]   fail_idx,
    output logic [15:0]         fail_result,
    output logic [15:0]         fail_expected,
    output logic [3:0]          fail_flags,
    output logic [3:0]          fail_flagsexp
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, nvecs_q, vnum_q, fail_idx_q;
    logic [31:0]       err_q;
    logic [15:0]       x_q, y_q, z_q, rexp_q, fail_res_q, fail_exp_q;
    logic [5:0]        ctrl_q;
    logic              fail_valid_q;
    logic              start_run, last_vec, mismatch;

    assign start_run = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign last_vec  = (idx_q + ADDR_W'(1)) == nvecs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mif.mem_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) state_d = (nvecs == '0) ? DONE : FETCH;
            end
            FETCH: begin
                mif.mem_en = 1'b1;
                busy       = 1'b1;
                state_d    = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                busy    = 1'b1;
                state_d = last_vec ? DONE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mif.mem_addr = (state_q == FETCH) ? idx_q : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q        <= '0;
            nvecs_q      <= '0;
            vnum_q       <= '0;
            err_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            ctrl_q       <= '0;
            rexp_q       <= '0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
            fail_res_q   <= '0;
            fail_exp_q   <= '0;
        end else begin
            if (start_run) begin
                nvecs_q      <= nvecs;
                idx_q        <= '0;
                vnum_q       <= '0;
                err_q        <= '0;
                fail_valid_q <= 1'b0;
                fail_idx_q   <= '0;
                fail_res_q   <= '0;
                fail_exp_q   <= '0;
            end
            if (state_q == LOAD) begin
                x_q    <= mif.mem_data[75:60];
                y_q    <= mif.mem_data[59:44];
                z_q    <= mif.mem_data[43:28];
                ctrl_q <= mif.mem_data[25:20];
                rexp_q <= mif.mem_data[19:4];
            end
            if (state_q == CHECK) begin
                idx_q  <= idx_q + ADDR_W'(1);
                vnum_q <= vnum_q + ADDR_W'(1);
                if (mismatch) begin
                    if (err_q != 32'hFFFF_FFFF) err_q <= err_q + 32'd1;
                    // Only the first failure is kept; later ones just count.
                    if (!fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_idx_q   <= idx_q;
                        fail_res_q   <= mif.result;
                        fail_exp_q   <= rexp_q;
                    end
                end
            end
        end
    end

`ifdef FMA16_RUNNER_FLAGS_EN
    logic [3:0] fexp_q, fail_flg_q, fail_flgexp_q;

    assign mismatch = (mif.result != rexp_q) || (mif.flags != fexp_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fexp_q        <= '0;
            fail_flg_q    <= '0;
            fail_flgexp_q <= '0;
        end else begin
            if (start_run) begin
                fail_flg_q    <= '0;
                fail_flgexp_q <= '0;
            end
            if (state_q == LOAD) fexp_q <= mif.mem_data[3:0];
            if ((state_q == CHECK) && mismatch && !fail_valid_q) begin
                fail_flg_q    <= mif.flags;
                fail_flgexp_q <= fexp_q;
            end
        end
    end

    assign fail_flags    = fail_flg_q;
    assign fail_flagsexp = fail_flgexp_q;
`else
    logic unused_flags;
    assign unused_flags  = ^{mif.flags, mif.mem_data[3:0]};
    assign mismatch      = (mif.result != rexp_q);
    assign fail_flags    = 4'h0;
    assign fail_flagsexp = 4'h0;
`endif

    // ctrl[7:6] of each vector are reserved.
    logic unused_ctrl;
    assign unused_ctrl = ^mif.mem_data[27:26];

    assign mif.x         = x_q;
    assign mif.y         = y_q;
    assign mif.z         = z_q;
    assign mif.roundmode = ctrl_q[5:4];
    assign mif.mul       = ctrl_q[3];
    assign mif.add       = ctrl_q[2];
    assign mif.negp      = ctrl_q[1];
    assign mif.negz      = ctrl_q[0];

    assign vectornum     = vnum_q;
    assign errors        = err_q;
    assign fail_valid    = fail_valid_q;
    assign fail_idx      = fail_idx_q;
    assign fail_result   = fail_res_q;
    assign fail_expected = fail_exp_q;
endmodule

// File: doc/fma16_vec_runner.md
# fma16_vec_runner

Hardware test-vector sequencer and checker for the `fma16` datapath. It fetches packed 76-bit vectors from a synchronous-read vector memory and unpacks them onto the `fma16` operand and control inputs. It then compares the combinational `result`/`flags` against the expected fields, counting mismatches and latching the first failure. It sits directly upstream of `fma16` (driving it) and downstream of it (consuming its outputs), so FPGA or emulation runs can self-check without a simulator bench.

## Interface
- `ADDR_W`, 20: vector memory address width; also the width of the vector count and index.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `nvecs`  in  ADDR_W  number of vectors to run; sampled with `start`
- `mem_en`  out  1  read enable to vector memory
- `mem_addr`  out  ADDR_W  vector address
- `mem_data`  in  76  read data, valid 1 cycle after `mem_en`
- `x`, `y`, `z`  out  16 each  fma16 operands
- `mul`, `add`, `negp`, `negz`  out  1 each  fma16 controls
- `roundmode`  out  2  fma16 rounding mode
- `result`  in  16  fma16 result
- `flags`  in  4  fma16 flags {Invalid, Overflow, Underflow, Inexact}
- `busy`  out  1  run in progress
- `done`  out  1  run finished; held until next `start`
- `vectornum`  out  ADDR_W  vectors checked so far in this run
- `errors`  out  32  mismatch count, saturating
- `fail_valid`  out  1  sticky; a mismatch has been latched
- `fail_idx`  out  ADDR_W  index of first failing vector
- `fail_result`, `fail_expected`  out  16 each  DUT and expected result of first failure
- `fail_flags`, `fail_flagsexp`  out  4 each  DUT and expected flags of first failure

## Operation
- Vector layout: [75:60] x, [59:44] y, [43:28] z, [27:20] ctrl, [19:4] rexpected, [3:0] flagsexpected. Only ctrl[5:0] is used: {roundmode[1:0], mul, add, negp, negz}. ctrl[7:6] are ignored.
- FSM states: IDLE, FETCH, LOAD, CHECK, DONE.
  - IDLE/DONE + `start`:
    - Clear `vectornum`, `errors`, and all `fail_*` registers. Latch `nvecs`, with `idx`=0.
    - Go to FETCH. If `nvecs`==0, go directly to DONE.
  - FETCH: `mem_en`=1, `mem_addr`=`idx`. Next state is LOAD.
  - LOAD: register all `mem_data` fields into the operand/control output registers and the internal expected registers. Next state is CHECK.
  - CHECK: a mismatch is `result` != rexpected, OR `flags` != flagsexpected (flags term only when the config macro is defined). On mismatch:
    - `errors`+1, holding at 0xFFFF_FFFF.
    - If `fail_valid`=0, latch `fail_*` and set `fail_valid`.
    - Then increment `vectornum` and `idx`. If `idx`+1 == latched `nvecs`, go to DONE; otherwise go to FETCH.
  - DONE: `done`=1, `busy`=0. `start` restarts.
- `start` is ignored in FETCH/LOAD/CHECK. `nvecs` changes during a run have no effect.
- `busy`=1 in FETCH, LOAD and CHECK.
- Compare is exact bit equality. No NaN canonicalisation.
- Reset mid-run: the run is aborted immediately and all state returns to the reset values.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `x`/`y`/`z`/controls, `mem_en`, `mem_addr`, `busy`, `done`, `vectornum`, `errors`, and all `fail_*`.
- Latency is 3 cycles per vector: FETCH, LOAD, CHECK.
  - Operands change at the end of LOAD.
  - `fma16` has one full cycle (CHECK) to settle before the compare edge.
- A run of N vectors: `done` rises 3N+1 cycles after the `start` edge. For N=0, `done` rises 1 cycle after the `start` edge.
- Operand outputs hold their last vector through DONE and IDLE.
- `mem_en` is high exactly one cycle per vector.

## Configuration
- `FMA16_RUNNER_FLAGS_EN` defined: flags mismatch counts as an error, and `fail_flags`/`fail_flagsexp` are latched.
- Macro undefined:
  - Only `result` is compared. `flags`/flagsexpected do not affect `errors`.
  - `fail_flags` and `fail_flagsexp` are tied to 0.

## Test plan
- Reset, then `start` with `nvecs`=0:
  - DONE one cycle later, `errors`=0, `vectornum`=0, `mem_en` never asserted.
- 4 vectors, all matching, e.g. x=3C00 y=3C00 z=0000 ctrl=0x08 rexp=3C00 flagsexp=0:
  - `done` at cycle 13, `errors`=0, `vectornum`=4, `fail_valid`=0.
  - `mem_addr` sequence 0,1,2,3.
- 5 vectors with result mismatches at idx 1 and 3 (model returns 0x4000 for expected 0x3E00):
  - `errors`=2, `fail_idx`=1, `fail_result`=4000, `fail_expected`=3E00.
- Result matches but `flags`=0001 vs flagsexp=0000:
  - With `FMA16_RUNNER_FLAGS_EN`: `errors`=1, `fail_flags`=0001.
  - Without the macro: `errors`=0.
- Assert `reset` low during CHECK of vector 2 of 6:
  - All outputs 0 and state IDLE immediately.
  - A new `start` re-runs from idx 0 and `errors` restarts at 0.
- Pulse `start` during LOAD with `nvecs`=9: ignored, and the run completes with the original count.
